cpack_timestamp_sched: RTL and testbench

- Sits between the channel packer output (64-bit packed beats) and the ADC DMA FIFO write port.
- Splits the packed stream into blocks of timestamp_every data beats.
- Precedes each block with one 64-bit header beat carrying the timestamp sampled when the block's first data beat arrived.
- Host software can then match every DMA buffer to a sample time.

---
 rtl/cpack_timestamp_sched.sv | 143 ++++++++++++++
 tb/tb_cpack_timestamp_sched.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpack_timestamp_sched.sv
// cpack_timestamp_sched
//   Sits between the channel packer and the ADC DMA FIFO write port. It cuts
//   the packed stream into blocks of timestamp_every data beats. Each block is
//   preceded by one header beat that carries the timestamp sampled when the
//   block's first data beat arrived.
//
// Ports
//   clk, reset          sample clock, async active-high reset
//   enable              header insertion enable (sampled at block boundaries)
//   timestamp           free-running sample timestamp
//   timestamp_every     data beats per block (sampled at block start)
//   in_wr_en/sync/data  packed beat from the packer
//   in_wr_overflow      out_wr_overflow | spacing_err back to the packer
//   out_wr_en/sync/data beat to the FIFO (header or data)
//   out_wr_overflow     FIFO overflow from downstream
//   spacing_err         sticky flag: a beat was dropped (too close to a start)
//   header_count        headers emitted, wrapping
//   err_clear           synchronous clear of spacing_err
//
// All outputs are registered, so a beat taken at cycle t leaves at t+1. The
// header is registered on the edge that takes the START beat, which makes the
// HDR cycle the one where the header is visible. The held first beat follows
// in FIRST. Any beat arriving in HDR or FIRST has no output slot, so it is
// dropped.
module cpack_timestamp_sched #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [63:0]            timestamp,
  input  logic [COUNT_WIDTH-1:0] timestamp_every,
  input  logic                   in_wr_en,
  input  logic                   in_wr_sync,
  input  logic [63:0]            in_wr_data,
  output logic                   in_wr_overflow,
  output logic                   out_wr_en,
  output logic                   out_wr_sync,
  output logic [63:0]            out_wr_data,
  input  logic                   out_wr_overflow,
  output logic                   spacing_err,
  output logic [COUNT_WIDTH-1:0] header_count,
  input  logic                   err_clear
);

  typedef enum logic [2:0] {BYPASS, HDR, FIRST, STREAM, BLOCK_END} state_t;

  state_t                 state, state_nxt;
  logic [COUNT_WIDTH-1:0] remaining, remaining_nxt;
  logic [63:0]            hold, hold_nxt;
  logic                   en_nxt, sync_nxt, hdr_inc, drop, start, can_start;
  logic [63:0]            data_nxt;

  assign can_start      = enable && (timestamp_every != '0);
  assign in_wr_overflow = out_wr_overflow | spacing_err;

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    hold_nxt      = hold;
    en_nxt        = 1'b0;
    sync_nxt      = 1'b0;
    data_nxt      = in_wr_data;
    hdr_inc       = 1'b0;
    drop          = 1'b0;
    start         = 1'b0;
    case (state)
      BYPASS: begin
        if (in_wr_en) begin
          if (in_wr_sync && can_start) start = 1'b1;
          else begin
            en_nxt   = 1'b1;
            sync_nxt = in_wr_sync;
          end
        end
      end
      HDR: begin
        // Header is on the output now; queue the held first beat behind it.
        drop      = in_wr_en;
        en_nxt    = 1'b1;
        data_nxt  = hold;
        state_nxt = FIRST;
      end
      FIRST: begin
        drop      = in_wr_en;
        state_nxt = (remaining == '0) ? BLOCK_END : STREAM;
      end
      STREAM: begin
        if (in_wr_en) begin
          en_nxt        = 1'b1;
          remaining_nxt = remaining - 1'b1;
          if (remaining == COUNT_WIDTH'(1)) state_nxt = BLOCK_END;
        end
      end
      BLOCK_END: begin
        // Sync flag is irrelevant here: blocks tile back to back.
        if (in_wr_en) begin
          if (can_start) start = 1'b1;
          else begin
            en_nxt    = 1'b1;
            sync_nxt  = in_wr_sync;
            state_nxt = BYPASS;
          end
        end
      end
      default: state_nxt = BYPASS;
    endcase
    if (start) begin
      state_nxt     = HDR;
      remaining_nxt = timestamp_every - 1'b1;
      hold_nxt      = in_wr_data;
      en_nxt        = 1'b1;
      sync_nxt      = 1'b1;
      data_nxt      = timestamp;
      hdr_inc       = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= BYPASS;
      remaining    <= '0;
      hold         <= '0;
      out_wr_en    <= 1'b0;
      out_wr_sync  <= 1'b0;
      out_wr_data  <= '0;
      spacing_err  <= 1'b0;
      header_count <= '0;
    end else begin
      state       <= state_nxt;
      remaining   <= remaining_nxt;
      hold        <= hold_nxt;
      out_wr_en   <= en_nxt;
      out_wr_sync <= sync_nxt;
      if (en_nxt) out_wr_data <= data_nxt;
      if (hdr_inc) header_count <= header_count + 1'b1;
      // A new drop beats a clear in the same cycle.
      if (drop) spacing_err <= 1'b1;
      else if (err_clear) spacing_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cpack_timestamp_sched.sv
module tb_cpack_timestamp_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [63:0] ts = '0;
  logic [31:0] every = 32'd0;
  logic        wr_en = 1'b0, sync = 1'b0;
  logic [63:0] data = '0;
  logic        in_ovf;
  logic        o_en, o_sync;
  logic [63:0] o_data;
  logic        ovf = 1'b0;
  logic        sp_err;
  logic [31:0] hdr_cnt;
  logic        err_clear = 1'b0;

  cpack_timestamp_sched #(.COUNT_WIDTH(32)) dut (
    .clk(clk), .reset(rst), .enable(enable), .timestamp(ts),
    .timestamp_every(every), .in_wr_en(wr_en), .in_wr_sync(sync),
    .in_wr_data(data), .in_wr_overflow(in_ovf), .out_wr_en(o_en),
    .out_wr_sync(o_sync), .out_wr_data(o_data), .out_wr_overflow(ovf),
    .spacing_err(sp_err), .header_count(hdr_cnt), .err_clear(err_clear)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct { int c; logic [63:0] d; logic s; } exp_t;
  exp_t q[$];

  // Reference model: block bookkeeping in terms of beats left in the block.
  logic [31:0] left;
  bit          at_end;
  int          busy_until;
  int          m_hdr;
  bit          m_err;

  function automatic void push(int c, logic [63:0] d, logic s);
    exp_t e;
    e.c = c; e.d = d; e.s = s;
    q.push_back(e);
  endfunction

  function automatic void model_reset();
    q.delete();
    left = 0; at_end = 0; busy_until = -1; m_hdr = 0; m_err = 0;
  endfunction

  function automatic void model(int c);
    bit dr, st;
    dr = 0;
    if (wr_en) begin
      if (c <= busy_until) begin
        dr = 1; m_err = 1;
      end else if (left > 0) begin
        push(c + 1, data, 1'b0);
        left--;
        if (left == 0) at_end = 1;
      end else begin
        st = enable && (every != 0) && (sync || at_end);
        at_end = 0;
        if (st) begin
          push(c + 1, ts, 1'b1);
          push(c + 2, data, 1'b0);
          m_hdr++;
          left = every - 1;
          at_end = (left == 0);
          busy_until = c + 2;
        end else push(c + 1, data, sync);
      end
    end
    if (err_clear && !dr) m_err = 0;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // Output monitor: every FIFO write must match the head of the scoreboard
  // in data, sync flag and arrival cycle; an overdue entry is a miss.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_en) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat cyc %0d data %0h", cyc, o_data);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (e.c != cyc || e.d !== o_data || e.s !== o_sync) begin
            errors++;
            $display("FAIL beat got cyc %0d data %0h sync %0b want cyc %0d data %0h sync %0b",
                     cyc, o_data, o_sync, e.c, e.d, e.s);
          end
        end
      end else if (q.size() > 0 && q[0].c <= cyc) begin
        exp_t e;
        e = q.pop_front();
        checks++; errors++;
        $display("FAIL missing_beat cyc %0d want data %0h at cyc %0d", cyc, e.d, e.c);
      end
    end
  end

  task automatic step(input logic e, input logic s, input logic [63:0] d);
    wr_en = e; sync = s; data = d; ts = 64'(100 + cyc);
    model(cyc);
    @(posedge clk); #1;
    wr_en = 0; sync = 0; err_clear = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 64'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic settle(input string name);
    idle(4);
    chk({name, "_drained"}, 64'(q.size()), 64'd0);
    chk({name, "_hdr"}, 64'(hdr_cnt), 64'(m_hdr));
    chk({name, "_err"}, 64'(sp_err), 64'(m_err));
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_en", 64'(o_en), 64'd0);
    chk("rst_sync", 64'(o_sync), 64'd0);
    chk("rst_data", o_data, 64'd0);
    chk("rst_hdr", 64'(hdr_cnt), 64'd0);
    chk("rst_err", 64'(sp_err), 64'd0);
    chk("rst_ovf", 64'(in_ovf), 64'd0);
    rst = 1'b0;

    // Bypass: plain forwarding, no headers.
    enable = 0; every = 3;
    step(1, 1, 64'hA); idle(4);
    step(1, 0, 64'hB); idle(4);
    settle("bypass");
    chk("bypass_hdr0", 64'(hdr_cnt), 64'd0);

    // Two blocks of 3; the fourth beat starts block 2 with no sync.
    do_reset();
    enable = 1; every = 3;
    step(1, 1, 64'hD0); idle(4);
    step(1, 0, 64'hD1); idle(4);
    step(1, 0, 64'hD2); idle(4);
    step(1, 0, 64'hD3); idle(4);
    step(1, 0, 64'hD4); idle(4);
    settle("blocks");
    chk("blocks_hdr2", 64'(hdr_cnt), 64'd2);

    // No sync beat ever seen: stays in bypass.
    do_reset();
    enable = 1; every = 2;
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 64'(16 + i)); idle(2);
    end
    settle("nosync");
    chk("nosync_hdr0", 64'(hdr_cnt), 64'd0);

    // Spacing violation, clear, then clear colliding with a new drop.
    do_reset();
    enable = 1; every = 3;
    step(1, 1, 64'hC0);
    step(1, 0, 64'hC1);
    settle("space");
    chk("space_err1", 64'(sp_err), 64'd1);
    chk("space_ovf", 64'(in_ovf), 64'd1);
    err_clear = 1; step(0, 0, 0);
    settle("clear");
    chk("clear_err0", 64'(sp_err), 64'd0);
    step(1, 0, 64'hC2); step(1, 0, 64'hC3);
    step(1, 0, 64'hC4);
    err_clear = 1; step(1, 0, 64'hC5);
    settle("clrwin");
    chk("clrwin_err1", 64'(sp_err), 64'd1);
    ovf = 1; #1;
    chk("ovf_pass", 64'(in_ovf), 64'd1);
    ovf = 0;

    // Enable dropped mid-block: block still completes with 4 data beats.
    do_reset();
    enable = 1; every = 4;
    step(1, 1, 64'hE0); idle(2);
    enable = 0;
    step(1, 0, 64'hE1); step(1, 0, 64'hE2); step(1, 1, 64'hE3);
    step(1, 0, 64'hE4); step(1, 1, 64'hE5);
    settle("endis");
    chk("endis_hdr1", 64'(hdr_cnt), 64'd1);

    // every = 1: header, beat, header, beat.
    do_reset();
    enable = 1; every = 1;
    for (int i = 0; i < 3; i++) begin
      step(1, (i == 0), 64'(48 + i)); idle(2);
    end
    settle("every1");
    chk("every1_hdr3", 64'(hdr_cnt), 64'd3);

    // Reset while the header is on the output.
    do_reset();
    enable = 1; every = 3;
    step(1, 1, 64'h77);
    rst = 1'b1;
    #1;
    model_reset();
    chk("rsthdr_en", 64'(o_en), 64'd0);
    chk("rsthdr_cnt", 64'(hdr_cnt), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    settle("rsthdr");

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 40) == 0) enable = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 40) == 0) every = $urandom_range(0, 4);
      err_clear = ($urandom_range(0, 19) == 0);
      ovf = ($urandom_range(0, 9) == 0);
      step($urandom_range(0, 1) == 1, $urandom_range(0, 9) < 3,
           {$urandom, $urandom});
    end
    ovf = 0;
    settle("rand");
    chk("rand_ovf", 64'(in_ovf), 64'(m_err));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
